cpu_alu: RTL and testbench

//  32-bit integer ALU for the EX stage: logic, signed/unsigned add/sub, logical shifts.

---
 rtl/cpu_alu_pkg.sv | 40 ++++
 rtl/cpu_alu_comb.sv | 52 +++++
 rtl/cpu_alu.sv | 37 +++
 tb/tb_cpu_alu.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/cpu_alu_pkg.sv
// Shared ALU definitions: widths and opcode encodings.
// Imported by the combinational core and the registered wrapper.
package cpu_alu_pkg;

    localparam int WORD_DATA_W = 32;
    localparam int ALU_OP_W    = 4;
    localparam int SHAMT_W     = $clog2(WORD_DATA_W);

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_OP_NOP  = 4'd0,
        ALU_OP_AND  = 4'd1,
        ALU_OP_OR   = 4'd2,
        ALU_OP_XOR  = 4'd3,
        ALU_OP_ADDS = 4'd4,
        ALU_OP_ADDU = 4'd5,
        ALU_OP_SUBS = 4'd6,
        ALU_OP_SUBU = 4'd7,
        ALU_OP_SHRL = 4'd8,
        ALU_OP_SHLL = 4'd9
    } alu_op_e;

    // Signed overflow of a+b: equal operand signs, result sign differs.
    function automatic logic add_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic r_msb
    );
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Signed overflow of a-b: differing operand signs, result sign differs from a.
    function automatic logic sub_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic r_msb
    );
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/cpu_alu_comb.sv
// Pure combinational ALU datapath: result and signed-overflow flag.
// Unused opcodes (10-15) produce zero with no overflow.
module cpu_alu_comb
    import cpu_alu_pkg::*;
(
    input  logic [WORD_DATA_W-1:0] in_0,
    input  logic [WORD_DATA_W-1:0] in_1,
    input  logic [ALU_OP_W-1:0]    op,
    output logic [WORD_DATA_W-1:0] res,
    output logic                   ovf
);

    localparam int MSB = WORD_DATA_W - 1;

    logic [WORD_DATA_W-1:0] sum;
    logic [WORD_DATA_W-1:0] diff;
    logic [SHAMT_W-1:0]     shamt;

    // Modulo-2^W arithmetic; carry and borrow out are dropped.
    assign sum   = in_0 + in_1;
    assign diff  = in_0 - in_1;
    assign shamt = in_1[SHAMT_W-1:0];

    // Opcode decode into result and overflow.
    always_comb begin
        res = '0;
        ovf = 1'b0;
        unique case (alu_op_e'(op))
            ALU_OP_NOP:  res = in_0;
            ALU_OP_AND:  res = in_0 & in_1;
            ALU_OP_OR:   res = in_0 | in_1;
            ALU_OP_XOR:  res = in_0 ^ in_1;
            ALU_OP_ADDS: begin
                res = sum;
                ovf = add_ovf(in_0[MSB], in_1[MSB], sum[MSB]);
            end
            ALU_OP_ADDU: res = sum;
            ALU_OP_SUBS: begin
                res = diff;
                ovf = sub_ovf(in_0[MSB], in_1[MSB], diff[MSB]);
            end
            ALU_OP_SUBU: res = diff;
            ALU_OP_SHRL: res = in_0 >> shamt;
            ALU_OP_SHLL: res = in_0 << shamt;
            default: begin
                res = '0;
                ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cpu_alu.sv
// EX-stage ALU: combinational core followed by a result/overflow register.
// One-cycle latency, a new operation accepted on every clock.
module cpu_alu
    import cpu_alu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_DATA_W-1:0] in_0,
    input  logic [WORD_DATA_W-1:0] in_1,
    input  logic [ALU_OP_W-1:0]    op,
    output logic [WORD_DATA_W-1:0] out,
    output logic                   of
);

    logic [WORD_DATA_W-1:0] res;
    logic                   ovf;

    cpu_alu_comb u_comb (
        .in_0 (in_0),
        .in_1 (in_1),
        .op   (op),
        .res  (res),
        .ovf  (ovf)
    );

    // Capture the ALU result; async reset clears it for the forwarding path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= '0;
            of  <= 1'b0;
        end else begin
            out <= res;
            of  <= ovf;
        end
    end

endmodule

// File: tb/tb_cpu_alu.sv
// Scoreboard bench for cpu_alu: driver pushes expectations,
// monitor pops one per clock and compares.
module tb_cpu_alu;

    logic        clk;
    logic        reset;
    logic [31:0] in_0;
    logic [31:0] in_1;
    logic [3:0]  op;
    logic [31:0] out;
    logic        of;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        f;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] r;
        logic        f;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    cpu_alu dut (
        .clk   (clk),
        .reset (reset),
        .in_0  (in_0),
        .in_1  (in_1),
        .op    (op),
        .out   (out),
        .of    (of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       name,
        input logic [31:0] got_r,
        input logic        got_f,
        input logic [31:0] exp_r,
        input logic        exp_f
    );
        n_assert++;
        if (got_r !== exp_r || got_f !== exp_f) begin
            n_fail++;
            $display("FAIL %s: got out=%h of=%b, need out=%h of=%b",
                     name, got_r, got_f, exp_r, exp_f);
        end
    endtask

    task automatic add(
        input string       name,
        input logic [3:0]  o,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] r,
        input logic        f
    );
        vec_t v;
        v.name = name; v.op = o; v.a = a;
        v.b = b; v.r = r; v.f = f;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        @(negedge clk);
        reset = 1'b0;
        op   = v.op;
        in_0 = v.a;
        in_1 = v.b;
        e.name = v.name; e.r = v.r; e.f = v.f;
        sb.push_back(e);
    endtask

    // Monitor: result for inputs issued before an edge appears after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.name, out, of, e.r, e.f);
            end
        end
    end

    initial begin
        add("and",       4'd1,  32'h0000000F, 32'h000000F0, 32'h00000000, 1'b0);
        add("or",        4'd2,  32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0);
        add("xor",       4'd3,  32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0);
        add("adds",      4'd4,  32'h01020304, 32'h00010203, 32'h01030507, 1'b0);
        add("adds_pov",  4'd4,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b1);
        add("adds_nov",  4'd4,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1);
        add("addu",      4'd5,  32'hEFFFFFFF, 32'h00000001, 32'hF0000000, 1'b0);
        add("addu_wrap", 4'd5,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
        add("addu_msb",  4'd5,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0);
        add("subs",      4'd6,  32'h00000005, 32'h00000002, 32'h00000003, 1'b0);
        add("subs_neg",  4'd6,  32'h00000001, 32'h00000002, 32'hFFFFFFFF, 1'b0);
        add("subs_nov",  4'd6,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1);
        add("subs_pov",  4'd6,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        add("subu",      4'd7,  32'h00000001, 32'h00000002, 32'hFFFFFFFF, 1'b0);
        add("subu_msb",  4'd7,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0);
        add("shrl",      4'd8,  32'hF0F0F0F0, 32'h00000004, 32'h0F0F0F0F, 1'b0);
        add("shll",      4'd9,  32'h0F0F0F0F, 32'h00000004, 32'hF0F0F0F0, 1'b0);
        add("shll_hi",   4'd9,  32'h0F0F0F0F, 32'hFFFFFFE4, 32'hF0F0F0F0, 1'b0);
        add("shrl_31",   4'd8,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0);
        add("shll_0",    4'd9,  32'h12345678, 32'h00000000, 32'h12345678, 1'b0);
        add("shrl_32",   4'd8,  32'h0000AAAA, 32'h00000020, 32'h0000AAAA, 1'b0);
        add("nop",       4'd0,  32'h00001234, 32'h0000FFFF, 32'h00001234, 1'b0);
        add("op10",      4'd10, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000000, 1'b0);
        add("op15",      4'd15, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
        add("post_rst",  4'd4,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1);
        add("b2b_and",   4'd1,  32'hFFFF0000, 32'h12345678, 32'h12340000, 1'b0);

        reset = 1'b1;
        op    = 4'd4;
        in_0  = 32'h7FFFFFFF;
        in_1  = 32'h7FFFFFFF;
        #1;
        check("rst_async", out, of, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold", out, of, 32'h0, 1'b0);

        for (int i = 0; i < 24; i++) drive(vecs[i]);

        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid", out, of, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check("rst_mid_hold", out, of, 32'h0, 1'b0);

        for (int i = 24; i < vecs.size(); i++) drive(vecs[i]);

        begin
            int budget;
            budget = 0;
            while (sb.size() > 0 && budget < 10) begin
                @(negedge clk);
                budget++;
            end
            if (sb.size() > 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL drain: %0d results pending, need 0",
                         sb.size());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
